// File: rtl/sram_mem_responder_if.sv
// MEM-stage data-memory request bus between the core (master) and the SRAM responder (slave).
interface sram_mem_responder_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_mem_responder.sv
// Serves MEM-stage word reads/writes against a 16-bit async SRAM as two half-word
// accesses followed by a programmable settle period; ~ready freezes the pipeline.
module sram_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_responder_if.slave  mem,
    output logic [17:0]          sram_addr,
    output logic [15:0]          sram_dq_out,
    input  logic [15:0]          sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR_LO = 3'd1;
    localparam logic [2:0] WR_HI = 3'd2;
    localparam logic [2:0] RD_LO = 3'd3;
    localparam logic [2:0] RD_HI = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [16:0] widx;
    logic [31:0] data_q;
    logic [16:0] widx_next;

    // Word index of the offset into SRAM space; wraps mod 2^32 with no range check.
    assign widx_next = 17'((mem.address - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            widx          <= '0;
            data_q        <= '0;
            mem.read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem.wr_en || mem.rd_en) begin
                        state  <= mem.wr_en ? WR_LO : RD_LO;
                        widx   <= widx_next;
                        data_q <= mem.write_data;
                    end
                end
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    state <= WAIT;
                    cnt   <= WAIT_INIT;
                end
                RD_LO: begin
                    mem.read_data[15:0] <= sram_dq_in;
                    state               <= RD_HI;
                end
                RD_HI: begin
                    mem.read_data[31:16] <= sram_dq_in;
                    state                <= WAIT;
                    cnt                  <= WAIT_INIT;
                end
                WAIT: begin
                    // A count of 0 or 1 both finish here, so WAIT always lasts max(WAIT_CYCLES,1).
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        mem.ready   = 1'b0;
        case (state)
            IDLE: mem.ready = ~(mem.wr_en | mem.rd_en);
            WR_LO: begin
                sram_addr   = {widx, 1'b0};
                sram_dq_out = data_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            WR_HI: begin
                sram_addr   = {widx, 1'b1};
                sram_dq_out = data_q[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            RD_LO:   sram_addr = {widx, 1'b0};
            RD_HI:   sram_addr = {widx, 1'b1};
            DONE:    mem.ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Scoreboard bench for sram_mem_responder: drivers push expected SRAM writes and
// completions into queues, negedge monitors pop and compare.
module tb_sram_mem_responder;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;

    typedef struct {
        logic [31:0] rd;
        int          c;
    } cmp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DUT with default parameters ----------------
    sram_mem_responder_if bus ();
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_mem_responder #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus.slave),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    logic [15:0] sram [0:63];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr[5:0]] <= sram_dq_out;
    assign sram_dq_in = sram[sram_addr[5:0]];

    // ---------------- DUT with WAIT_CYCLES = 0 ----------------
    sram_mem_responder_if bus0 ();
    logic [17:0] sram_addr0;
    logic [15:0] sram_dq_out0;
    logic [15:0] sram_dq_in0;
    logic        sram_dq_oe0;
    logic        sram_we_n0;

    sram_mem_responder #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus0.slave),
        .sram_addr  (sram_addr0),
        .sram_dq_out(sram_dq_out0),
        .sram_dq_in (sram_dq_in0),
        .sram_dq_oe (sram_dq_oe0),
        .sram_we_n  (sram_we_n0)
    );

    assign sram_dq_in0 = 16'(sram_addr0) ^ 16'h1111;

    // ---------------- scoreboards ----------------
    wr_t  wq[$];
    cmp_t cq[$];
    cmp_t cq0[$];
    int   done_cnt  = 0;
    int   done_cnt0 = 0;
    int   last_done = 0;

    always @(negedge clk) begin
        if (!sram_we_n) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%05h data 0x%04h, none required (cycle %0d)",
                         sram_addr, sram_dq_out, cyc);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("write_cycle", 32'(cyc), 32'(w.c));
                check("write_addr", {14'd0, sram_addr}, {14'd0, w.a});
                check("write_data", {16'd0, sram_dq_out}, {16'd0, w.d});
                check("write_oe", {31'd0, sram_dq_oe}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (bus.wr_en || bus.rd_en) && bus.ready) begin
            done_cnt++;
            last_done = cyc;
            if (cq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: ready high at cycle %0d, none required", cyc);
            end else begin
                cmp_t e;
                e = cq.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.c));
                check("read_data", bus.read_data, e.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (bus0.wr_en || bus0.rd_en) && bus0.ready) begin
            done_cnt0++;
            if (cq0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready0: ready high at cycle %0d, none required", cyc);
            end else begin
                cmp_t e;
                e = cq0.pop_front();
                check("w0_ready_cycle", 32'(cyc), 32'(e.c));
                check("w0_read_data", bus0.read_data, e.rd);
                check("w0_we_n", {31'd0, sram_we_n0}, 32'd1);
                check("w0_idle_bus", {15'd0, sram_dq_oe0, sram_dq_out0}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic push_write(input int start, input logic [17:0] lo, input logic [31:0] d);
        wq.push_back('{a: lo,         d: d[15:0],  c: start + 1});
        wq.push_back('{a: lo + 18'd1, d: d[31:16], c: start + 2});
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk);
        #1;
        if (done_cnt == d0) check("ready_timeout", 32'(done_cnt), 32'(d0 + 1));
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Called at posedge+1; default latency is 3 + max(2,1) = 5 cycles.
    task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] lo, input logic [31:0] exp_rd);
        int start;
        start          = cyc;
        bus.wr_en      = we;
        bus.rd_en      = re;
        bus.address    = a;
        bus.write_data = d;
        if (we) push_write(start, lo, d);
        cq.push_back('{rd: exp_rd, c: start + 5});
        wait_done();
    endtask

    initial begin
        int first_done;
        int start;
        int d0;
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.address     = '0;
        bus.write_data  = '0;
        bus0.wr_en      = 1'b0;
        bus0.rd_en      = 1'b0;
        bus0.address    = '0;
        bus0.write_data = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_ready0", {31'd0, bus0.ready}, 32'd1);

        // Write then read back at 1028 -> half-words 2 and 3
        do_req(1'b1, 1'b0, 32'd1028, 32'h12345678, 18'd2, 32'h00000000);
        do_req(1'b0, 1'b1, 32'd1028, 32'h0,        18'd2, 32'h12345678);

        // Both requests high: write wins, read_data untouched
        do_req(1'b1, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h12345678);

        // Back-to-back write then read at 1024
        do_req(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 18'd0, 32'h12345678);
        first_done = last_done;
        do_req(1'b0, 1'b1, 32'd1024, 32'h0,        18'd0, 32'hCAFEF00D);
        check("b2b_gap", 32'(last_done - first_done), 32'd6);

        // Reset during WR_HI with the request held high
        start          = cyc;
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1036;
        bus.write_data = 32'h0BADF00D;
        push_write(start, 18'd6, 32'h0BADF00D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_in_wr_hi", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("post_rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("post_rst_ready", {31'd0, bus.ready}, 32'd0);
        check("post_rst_read_data", bus.read_data, 32'd0);
        start = cyc;
        push_write(start, 18'd6, 32'h0BADF00D);
        cq.push_back('{rd: 32'h0, c: start + 5});
        wait_done();
        do_req(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 32'h0BADF00D);

        // WAIT_CYCLES = 0 instance: ready 4 cycles after the request
        start         = cyc;
        bus0.rd_en    = 1'b1;
        bus0.address  = 32'd1028;
        cq0.push_back('{rd: 32'h11121113, c: start + 4});
        d0 = done_cnt0;
        for (int i = 0; i < 40 && done_cnt0 == d0; i++) @(posedge clk);
        #1;
        if (done_cnt0 == d0) check("ready0_timeout", 32'(done_cnt0), 32'(d0 + 1));
        bus0.rd_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("cq_drained", 32'(cq.size()), 32'd0);
        check("cq0_drained", 32'(cq0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
